// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter sequencer with branch target selection and return-address stack
module pc_sequencer #(
    parameter int                WIDTH      = 64,
    parameter logic [WIDTH-1:0]  RESET_PC   = '0,
    parameter int                INST_SHIFT = 2,
    parameter int                RAS_DEPTH  = 4
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Stall,
    input  logic [WIDTH-1:0] SignExtImm,
    input  logic             Branch,
    input  logic             BranchNZ,
    input  logic             ALUZero,
    input  logic             Uncondbranch,
    input  logic             Link,
    input  logic             RegBranch,
    input  logic             Return,
    input  logic [WIDTH-1:0] RegTarget,
    output logic [WIDTH-1:0] CurrentPC,
    output logic [WIDTH-1:0] LinkAddr,
    output logic             Taken,
    output logic             RasEmpty,
    output logic             RasFull
);

    localparam int               PW      = $clog2(RAS_DEPTH);
    localparam logic [PW:0]      DEPTH_C = (PW + 1)'(RAS_DEPTH);
    localparam logic [WIDTH-1:0] INC     = WIDTH'(1) << INST_SHIFT;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [PW-1:0]    top_q, top_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [WIDTH-1:0] ras_d [RAS_DEPTH];

    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] rel_pc;
    logic [WIDTH-1:0] ras_top;
    logic [WIDTH-1:0] target;
    logic             taken;
    logic [PW-1:0]    top_inc;
    logic             do_push;
    logic             do_replace;
    logic             do_pop;

    assign seq_pc    = pc_q + INC;
    assign rel_pc    = pc_q + (SignExtImm << INST_SHIFT);
    assign ras_top   = ras_q[top_q];
    assign top_inc   = top_q + 1'b1;
    assign CurrentPC = pc_q;
    assign LinkAddr  = seq_pc;
    assign Taken     = taken;
    assign RasEmpty  = empty_q;
    assign RasFull   = full_q;

    // BL pushes; BL combined with a return swaps the top; a plain return pops
    assign do_push    = Uncondbranch & Link & ~Return;
    assign do_replace = Uncondbranch & Link & Return;
    assign do_pop     = Return & ~(Uncondbranch & Link) & ~empty_q;

    // Fixed-priority next-PC selection; anything but the sequential PC counts as taken
    always_comb begin
        target = seq_pc;
        taken  = 1'b1;
        if (Return && !empty_q) begin
            target = ras_top;
        end else if (Return || RegBranch) begin
            target = RegTarget;
        end else if (Uncondbranch) begin
            target = rel_pc;
        end else if (Branch && (ALUZero ^ BranchNZ)) begin
            target = rel_pc;
        end else begin
            target = seq_pc;
            taken  = 1'b0;
        end
    end

    // Next PC and RAS state; a stall freezes everything, the full RAS overwrites its oldest slot
    always_comb begin
        pc_d  = pc_q;
        top_d = top_q;
        cnt_d = cnt_q;
        ras_d = ras_q;
        if (!Stall) begin
            pc_d = target;
            if (do_replace && !empty_q) begin
                ras_d[top_q] = seq_pc;
            end else if (do_push || do_replace) begin
                top_d          = top_inc;
                ras_d[top_inc] = seq_pc;
                if (cnt_q != DEPTH_C) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (do_pop) begin
                top_d = top_q - 1'b1;
                cnt_d = cnt_q - 1'b1;
            end
        end
        empty_d = (cnt_d == '0);
        full_d  = (cnt_d == DEPTH_C);
    end

    // Control registers; reset overrides stall and every branch input
    always_ff @(posedge CLK) begin
        if (Reset) begin
            pc_q    <= RESET_PC;
            top_q   <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            top_q   <= top_d;
            cnt_q   <= cnt_d;
            empty_q <= empty_d;
            full_q  <= full_d;
        end
    end

    // RAS storage is not cleared; the count alone defines which entries are live
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            ras_q <= ras_d;
        end
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WIDTH, default 64, SHALL set the PC and address width in bits.
REQ-002 Parameter RESET_PC, default 0, SHALL set the PC value loaded on reset.
REQ-003 Parameter INST_SHIFT, default 2, SHALL set the left shift of the branch offset and the sequential increment (1<<INST_SHIFT).
REQ-004 Parameter RAS_DEPTH, default 4 (power of 2, >=2), SHALL set the return-address-stack entry count.
REQ-005 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 Stall  input  1  hold the PC and the RAS this cycle.
REQ-008 SignExtImm  input  WIDTH  sign-extended branch offset, in instructions.
REQ-009 Branch  input  1  conditional branch instruction.
REQ-010 BranchNZ  input  1  condition polarity: 0 = take on ALUZero=1 (CBZ); 1 = take on ALUZero=0 (CBNZ).
REQ-011 ALUZero  input  1  ALU zero flag.
REQ-012 Uncondbranch  input  1  PC-relative unconditional branch.
REQ-013 Link  input  1  with Uncondbranch: push the return address (BL).
REQ-014 RegBranch  input  1  branch to RegTarget (BR).
REQ-015 Return  input  1  return: predict from the RAS top.
REQ-016 RegTarget  input  WIDTH  register branch target.
REQ-017 CurrentPC  output  WIDTH  registered PC.
REQ-018 LinkAddr  output  WIDTH  CurrentPC + (1<<INST_SHIFT), combinational.
REQ-019 Taken  output  1  combinational; 1 when the next PC is not sequential.
REQ-020 RasEmpty, RasFull  output  1 each  registered RAS occupancy flags.

Function
REQ-021 SeqPC SHALL be CurrentPC + (1<<INST_SHIFT); RelPC SHALL be CurrentPC + (SignExtImm << INST_SHIFT). Both SHALL be computed modulo 2^WIDTH, with wrap-around permitted and no flag.
REQ-022 Target selection SHALL use this fixed priority:
  - Return with RAS non-empty -> RAS top.
  - Return with RAS empty -> RegTarget.
  - RegBranch -> RegTarget.
  - Uncondbranch -> RelPC.
  - Branch and (ALUZero XOR BranchNZ) -> RelPC.
  - Otherwise -> SeqPC.
REQ-023 Taken SHALL be 1 for every case in REQ-022 except SeqPC.
REQ-024 When Stall=0, CurrentPC SHALL load the selected target on the rising edge, giving one cycle of latency from the inputs to CurrentPC.
REQ-025 When Stall=1, CurrentPC, the RAS contents, the RAS pointer and the flags SHALL hold. Taken and LinkAddr SHALL still reflect the current inputs.
REQ-026 Push: Uncondbranch=1, Link=1, Return=0, Stall=0 SHALL write LinkAddr at the new top and increment the count, saturating at RAS_DEPTH.
REQ-027 Push when full SHALL overwrite the oldest entry (circular buffer); the count SHALL stay RAS_DEPTH and RasFull SHALL stay 1.
REQ-028 Pop: Return=1, Stall=0, RAS non-empty SHALL decrement the count. Return on an empty RAS SHALL leave the RAS unchanged.
REQ-029 Return=1 together with Link=1 and Uncondbranch=1:
  - The target SHALL follow REQ-022 (Return wins).
  - The RAS SHALL replace the top entry with LinkAddr; the count is unchanged; on an empty RAS this is a push.
REQ-030 Link without Uncondbranch SHALL have no effect.
REQ-031 RasEmpty SHALL equal (count==0) and RasFull SHALL equal (count==RAS_DEPTH), both updated with the count.

Reset
REQ-032 Reset=1 at a rising edge SHALL set:
  - CurrentPC=RESET_PC;
  - RAS count=0 and pointer=0;
  - RasEmpty=1 and RasFull=0.
REQ-033 Reset SHALL override Stall and all branch inputs in the same cycle, including a reset asserted mid-sequence with a full RAS.
REQ-034 The RAS entry contents need not be cleared by reset.
REQ-035 CurrentPC SHALL be RESET_PC on the first edge after Reset is released only if Stall=1; otherwise it SHALL advance per REQ-022.

Verification
REQ-036 Reset, then 3 idle cycles (WIDTH=64, RESET_PC=0) -> CurrentPC=0, 4, 8, 12; Taken=0.
REQ-037 CurrentPC=0x100, Branch=1, BranchNZ=0, ALUZero=1, SignExtImm=-2 -> next CurrentPC=0xF8. Same inputs with BranchNZ=1 -> next CurrentPC=0x104.
REQ-038 Sequence of BL, Return and Stall:
  - BL at 0x200 with imm=0x10 -> CurrentPC=0x240, RasEmpty=0.
  - Return next -> CurrentPC=0x204, RasEmpty=1.
  - Stall=1 during the Return -> CurrentPC stays 0x240 and the RAS is unchanged.
REQ-039 Push 5 BLs into RAS_DEPTH=4 from PCs A..E, then 4 Returns -> targets E+4, D+4, C+4, B+4; RasEmpty=1.
  - A 5th Return with RegTarget=0x800 -> 0x800.
REQ-040 Wrap-around: CurrentPC=0xFFFF_FFFF_FFFF_FFFC, idle -> CurrentPC=0. Priority: RegBranch=1 with Uncondbranch=1 -> RegTarget.
REQ-041 Reset asserted with RAS full and Stall=1 -> CurrentPC=RESET_PC, RasEmpty=1, RasFull=0 the next cycle.
